spram_arb2: RTL and testbench
=============================

# spram_arb2

Two-requester arbiter that shares one 16384x32 single-port SPRAM, built from two SP256K macros, between two bus masters, e.g. CPU data port and DMA engine. The block sits between the masters and the SPRAM wrapper, which it drives directly. Each cycle it issues at most one access, chosen by round-robin with optional per-master lock for atomic bursts. It returns read data with the SPRAM's one-cycle latency and a per-master valid strobe.

## Interface
- `ADDR_W`, 14, word address width; fixed by the SPRAM depth.
- `DATA_W`, 32, data width.
- `clk_i`  in  1  single clock; also drives the SPRAM `clk_i`.
- `rst_i`  in  1  synchronous, active-high reset.
- `mN_req_i`  in  1  master N (N=0,1) access request.
- `mN_lock_i`  in  1  master N holds ownership after its current grant while asserted.
- `mN_we_i`  in  1  1 = write, 0 = read.
- `mN_mask_i`  in  4  byte write enables, bit k enables byte k.
- `mN_addr_i`  in  ADDR_W  word address.
- `mN_wdata_i`  in  DATA_W  write data.
- `mN_gnt_o`  out  1  access accepted this cycle (req && gnt = transfer).
- `mN_rvalid_o`  out  1  read data valid for master N.
- `mN_rdata_o`  out  DATA_W  read data; equals `mem_rdata_i`.
- `mem_addr_o`  out  ADDR_W  to SPRAM `addr_i`.
- `mem_wr_en_o`  out  1  to SPRAM `wr_en_i`.
- `mem_mask_o`  out  4  to SPRAM `mask_we`.
- `mem_wdata_o`  out  DATA_W  to SPRAM `wr_data_i`.
- `mem_rdata_i`  in  DATA_W  from SPRAM `rd_data_o`.

## Operation
- Owner state: NONE, OWN0, OWN1. NONE is the reset state.
- NONE: grant is chosen by round-robin.
  - Only one master requests: that master is granted.
  - Both request: the master other than `last_q` is granted.
  - `last_q` resets to 1, so m0 wins the first contention.
- On any grant, `last_q` is set to the granted master.
- If the granted master has `mN_lock_i`=1 in the grant cycle, the next state is OWNN.
- OWNN: only master N can be granted; the other master's `gnt` is held 0.
- Stay in OWNN while `mN_lock_i`=1.
- Leave to NONE when `mN_lock_i`=0, with or without a request. Arbitration in that same cycle follows NONE rules, so the other master can be granted immediately.
- Grant is combinational from the requests and registered state. It does not depend on `mN_gnt_o` feedback.
- Memory mux:
  - With a grant, `mem_*` carry the granted master's `addr`/`we`/`mask`/`wdata`.
  - With no grant, `mem_wr_en_o`=0, `mem_mask_o`=0, and address/data are don't-care but held at the previous value.
- Reads: `rsel_q` and `rpend_q` record the granted master for a read. In the next cycle `m<rsel>_rvalid_o`=1; the other master's rvalid is 0.
- Writes produce no response.
- A write to an address and a read of the same address on the next grant returns the new data.
- `mN_lock_i` without `mN_req_i` in NONE has no effect.

## Timing
- Reset values:
  - All `gnt` and `rvalid` = 0; `mem_wr_en_o`=0; `mem_mask_o`=0.
  - Owner = NONE; `last_q`=1; `rpend_q`=0.
- While `rst_i`=1, all grants are forced to 0.
- Read latency: grant at cycle T gives `rvalid` and valid `rdata` at T+1. This matches the SPRAM registered output.
- Throughput: one access per cycle. Back-to-back reads from alternating masters give back-to-back rvalids, each routed to the correct master.
- Reset asserted in the cycle after a read grant: `rvalid` is 0 in the following cycle and the response is dropped. A master must discard outstanding reads on reset.
- Requests must stay stable until granted. A request dropped before grant is legal and leaves no state behind.
- The lock is sampled only in grant cycles (NONE) and every cycle in OWNN. No lock timeout.

## Structure
- Package `spram_arb_pkg`:
  - `ADDR_W`=14, `DATA_W`=32.
  - Enum `owner_t` {OWN_NONE, OWN_0, OWN_1}.
  - Typedef `mem_req_t` (addr, we, mask, wdata).
- Sub-module `rr_pick2`: combinational two-way round-robin picker with inputs req[1:0] and last, output onehot gnt[1:0].
- The SPRAM wrapper is instantiated by the parent, not inside this block.

## Test plan
- Reset then m0 and m1 both request reads of 0x0010/0x0020 → m0 granted at T, m1 at T+1. `m0_rvalid` at T+1, `m1_rvalid` at T+2 with the correct data.
- m0 writes 0xDEADBEEF with mask 4'b0011 to 0x1234, then reads it (prior content 0) → data 0x0000BEEF, `m0_rvalid` one cycle after the read grant.
- m0 requests with lock=1 for 4 cycles while m1 requests continuously → m0 granted 4 cycles, m1 `gnt`=0 throughout. In the cycle m0 drops lock, m1 is granted.
- Only m1 requests for 3 cycles, then both request → m1 granted 3×, then m0 wins (last=1).
- Read granted at T, `rst_i`=1 at T+1 → both `rvalid`=0 at T+1 and T+2; the state returns to NONE with `last_q`=1.
- Idle cycles with no request → `mem_wr_en_o`=0, `mem_mask_o`=0, no `rvalid`, owner stays NONE.

Source files
------------

// File: rtl/spram_arb_pkg.sv
// spram_arb_pkg: shared widths, owner encoding and memory request bundle for spram_arb2
package spram_arb_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {OWN_NONE, OWN_0, OWN_1} owner_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [3:0]        mask;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker, favours the master that was not granted last
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o[0] = req_i[0] && (!req_i[1] || last_i);
    gnt_o[1] = req_i[1] && (!req_i[0] || !last_i);
  end
endmodule

// File: rtl/spram_arb2.sv
// spram_arb2: round-robin arbiter with per-master lock sharing one single-port SPRAM
module spram_arb2 import spram_arb_pkg::*; (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_lock_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_mask_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_lock_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_mask_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_en_o,
  output logic [3:0]        mem_mask_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  owner_t owner_q, owner_d;
  logic last_q, last_d, rpend_q, rpend_d, rsel_q, rsel_d, hold0, hold1;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0] rr_gnt, gnt;
  mem_req_t r0, r1, sel;
  rr_pick2 u_pick (
    .req_i ({m1_req_i, m0_req_i}),
    .last_i(last_q),
    .gnt_o (rr_gnt)
  );
  assign r0 = {m0_addr_i, m0_we_i, m0_mask_i, m0_wdata_i};
  assign r1 = {m1_addr_i, m1_we_i, m1_mask_i, m1_wdata_i};
  always_comb begin
    hold0 = owner_q == OWN_0 && m0_lock_i;
    hold1 = owner_q == OWN_1 && m1_lock_i;
    gnt = rst_i ? 2'b00 : hold0 ? {1'b0, m0_req_i} : hold1 ? {m1_req_i, 1'b0} : rr_gnt;
    owner_d = (hold0 || hold1) ? owner_q : (gnt[0] && m0_lock_i) ? OWN_0 :
              (gnt[1] && m1_lock_i) ? OWN_1 : OWN_NONE;
    last_d = gnt[1] ? 1'b1 : gnt[0] ? 1'b0 : last_q;
    sel = gnt[1] ? r1 : r0;
    rpend_d = |gnt && !sel.we;
    rsel_d = |gnt ? gnt[1] : rsel_q;
    mem_addr_o = |gnt ? sel.addr : addr_q;
    mem_wdata_o = |gnt ? sel.wdata : wdata_q;
    mem_wr_en_o = |gnt && sel.we;
    mem_mask_o = (|gnt && sel.we) ? sel.mask : 4'b0000;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      rpend_q <= 1'b0;
      rsel_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      rpend_q <= rpend_d;
      rsel_q  <= rsel_d;
      addr_q  <= mem_addr_o;
      wdata_q <= mem_wdata_o;
    end
  end
  // a reset landing on the response cycle drops the read
  assign m0_rvalid_o = rpend_q && !rsel_q && !rst_i;
  assign m1_rvalid_o = rpend_q && rsel_q && !rst_i;
  assign m0_rdata_o = mem_rdata_i;
  assign m1_rdata_o = mem_rdata_i;
  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];
endmodule

// File: tb/tb_spram_arb2.sv
// tb_spram_arb2: scenario tasks plus a read scoreboard against a behavioural SPRAM
module tb_spram_arb2;
  import spram_arb_pkg::*;
  logic clk = 1'b0, rst;
  logic m0_req, m0_lock, m0_we, m0_gnt, m0_rvalid;
  logic m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid;
  logic [3:0] m0_mask, m1_mask, mem_mask;
  logic [ADDR_W-1:0] m0_addr, m1_addr, mem_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic mem_wr_en;
  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:16383];
  typedef struct { bit m; logic [31:0] d; } exp_t;
  exp_t q[$];
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  spram_arb2 dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_lock_i(m0_lock), .m0_we_i(m0_we), .m0_mask_i(m0_mask),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_lock_i(m1_lock), .m1_we_i(m1_we), .m1_mask_i(m1_mask),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_wr_en_o(mem_wr_en), .mem_mask_o(mem_mask),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );
  function automatic logic [31:0] pat(int i);
    return (i < 'h1000) ? (32'h1357_0000 ^ (i * 3)) : 32'h0;
  endfunction
  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = pat(i);
      ref_mem[i] = pat(i);
    end
  end
  always @(posedge clk) begin
    if (mem_wr_en)
      for (int k = 0; k < 4; k++)
        if (mem_mask[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    mem_rdata <= mem[mem_addr];
  end
  // scoreboard: compare responses first, then record this cycle's grants
  always @(negedge clk) begin
    exp_t e;
    if (rst) q.delete();
    else begin
      if (m0_rvalid || m1_rvalid) begin
        checks++;
        if (q.size() == 0) $display("FAIL sb_unexpected rvalid=%b%b with no read outstanding", m1_rvalid, m0_rvalid);
        else begin
          e = q.pop_front();
          if ({m1_rvalid, m0_rvalid} !== (e.m ? 2'b10 : 2'b01) || (e.m ? m1_rdata : m0_rdata) !== e.d)
            $display("FAIL sb_read rvalid=%b%b data=%h/%h expected master %0d data %h",
                     m1_rvalid, m0_rvalid, m1_rdata, m0_rdata, e.m, e.d);
          else passes++;
        end
      end
      if (m0_gnt && m0_req) begin
        if (m0_we) begin
          for (int k = 0; k < 4; k++) if (m0_mask[k]) ref_mem[m0_addr][8*k +: 8] = m0_wdata[8*k +: 8];
        end else q.push_back('{m: 1'b0, d: ref_mem[m0_addr]});
      end
      if (m1_gnt && m1_req) begin
        if (m1_we) begin
          for (int k = 0; k < 4; k++) if (m1_mask[k]) ref_mem[m1_addr][8*k +: 8] = m1_wdata[8*k +: 8];
        end else q.push_back('{m: 1'b1, d: ref_mem[m1_addr]});
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    m0_req = 1'b1; m0_lock = 1'b0; m0_we = 1'b1; m0_mask = 4'hF; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b1; m1_lock = 1'b0; m1_we = 1'b1; m1_mask = 4'hF; m1_addr = '0; m1_wdata = '0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_wr_en, mem_mask} !== 9'b0)
      $display("FAIL reset gnt=%b%b rvalid=%b%b wr_en=%b mask=%b required all 0",
               m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_wr_en, mem_mask);
    else passes++;
    tick();
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0; m0_mask = '0; m1_mask = '0;
    tick();
  endtask
  task automatic test_contention();
    m0_req = 1'b1; m0_addr = 14'h0010; m1_req = 1'b1; m1_addr = 14'h0020;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL contention_first gnt=%b%b required 01", m1_gnt, m0_gnt);
    else passes++;
    tick(); m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid} !== 4'b1001)
      $display("FAIL contention_second gnt=%b%b rvalid=%b%b required 10/01", m1_gnt, m0_gnt, m1_rvalid, m0_rvalid);
    else passes++;
    tick(); m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b10 || m1_rdata !== pat('h20))
      $display("FAIL contention_m1_data rvalid=%b%b data=%h required 10 %h", m1_rvalid, m0_rvalid, m1_rdata, pat('h20));
    else passes++;
    tick();
  endtask
  task automatic test_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_mask = 4'b0011; m0_addr = 14'h1234; m0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || mem_wr_en !== 1'b1 || mem_mask !== 4'b0011 || mem_addr !== 14'h1234 || mem_wdata !== 32'hDEADBEEF)
      $display("FAIL write_mux gnt=%b wr_en=%b mask=%b addr=%h wdata=%h required 1 1 0011 1234 deadbeef",
               m0_gnt, mem_wr_en, mem_mask, mem_addr, mem_wdata);
    else passes++;
    tick(); m0_we = 1'b0; m0_mask = 4'b0000;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== 14'h1234)
      $display("FAIL read_mux gnt=%b wr_en=%b addr=%h required 1 0 1234", m0_gnt, mem_wr_en, mem_addr);
    else passes++;
    tick(); m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000BEEF)
      $display("FAIL write_read rvalid=%b data=%h required 1 0000beef", m0_rvalid, m0_rdata);
    else passes++;
    tick();
  endtask
  task automatic test_lock();
    m1_req = 1'b1; m1_addr = 14'h0040;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL lock_pre gnt=%b%b required 10", m1_gnt, m0_gnt);
    else passes++;
    tick(); m1_addr = 14'h0041; m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 14'h0030;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL lock_hold cycle %0d gnt=%b%b required 01", i, m1_gnt, m0_gnt);
      else passes++;
      tick(); m0_addr = 14'h0031 + 14'(i);
    end
    m0_lock = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL lock_release gnt=%b%b required 10", m1_gnt, m0_gnt);
    else passes++;
    tick(); m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL lock_after gnt=%b%b required 01", m1_gnt, m0_gnt);
    else passes++;
    tick(); m0_req = 1'b0;
  endtask
  task automatic test_m1_only();
    m1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m1_addr = 14'h0060 + 14'(i);
      @(negedge clk);
      checks++;
      if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL m1_only cycle %0d gnt=%b%b required 10", i, m1_gnt, m0_gnt);
      else passes++;
      tick();
    end
    m1_addr = 14'h0070; m0_req = 1'b1; m0_addr = 14'h0071;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL m1_only_then_both gnt=%b%b required 01", m1_gnt, m0_gnt);
    else passes++;
    tick(); m0_req = 1'b0; m1_req = 1'b0;
  endtask
  task automatic test_reset_drop();
    m0_req = 1'b1; m0_addr = 14'h0050;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) $display("FAIL rst_drop_grant gnt=%b required 1", m0_gnt);
    else passes++;
    tick(); m0_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL rst_drop_t1 rvalid=%b%b required 00", m1_rvalid, m0_rvalid);
    else passes++;
    tick(); rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL rst_drop_t2 rvalid=%b%b required 00", m1_rvalid, m0_rvalid);
    else passes++;
    tick(); m0_req = 1'b1; m0_addr = 14'h0051; m1_req = 1'b1; m1_addr = 14'h0052;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL rst_last_restored gnt=%b%b required 01", m1_gnt, m0_gnt);
    else passes++;
    tick(); m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL rst_then_m1 gnt=%b%b required 10", m1_gnt, m0_gnt);
    else passes++;
    tick(); m1_req = 1'b0;
  endtask
  task automatic test_idle();
    tick();
    for (int i = 0; i < 3; i++) begin
      m0_lock = (i == 2);
      @(negedge clk);
      checks++;
      if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_wr_en, mem_mask} !== 9'b0)
        $display("FAIL idle cycle %0d gnt=%b%b rvalid=%b%b wr_en=%b mask=%b required all 0",
                 i, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_wr_en, mem_mask);
      else passes++;
      tick();
    end
    m1_req = 1'b1; m1_addr = 14'h0080;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL lock_without_req gnt=%b%b required 10", m1_gnt, m0_gnt);
    else passes++;
    tick(); m1_req = 1'b0; m0_lock = 1'b0;
  endtask
  task automatic test_back_to_back();
    logic prev = 1'b1;
    m0_req = 1'b1; m0_addr = 14'h0100; m1_req = 1'b1; m1_addr = 14'h0200;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({m1_gnt, m0_gnt} !== (prev ? 2'b01 : 2'b10))
        $display("FAIL b2b_gnt cycle %0d gnt=%b%b required %b", i, m1_gnt, m0_gnt, prev ? 2'b01 : 2'b10);
      else passes++;
      if (i > 0) begin
        checks++;
        if ({m1_rvalid, m0_rvalid} !== (prev ? 2'b10 : 2'b01))
          $display("FAIL b2b_rvalid cycle %0d rvalid=%b%b required %b", i, m1_rvalid, m0_rvalid, prev ? 2'b10 : 2'b01);
        else passes++;
      end
      prev = ~prev;
      tick();
      if (prev) m1_addr = m1_addr + 14'd1;
      else m0_addr = m0_addr + 14'd1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_contention();
    test_write_read();
    test_lock();
    test_m1_only();
    test_reset_drop();
    test_idle();
    test_back_to_back();
    checks++;
    if (q.size() != 0) $display("FAIL sb_drain outstanding=%0d required 0", q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
